rob_nway: RTL and testbench

Parametrised N-wide reorder buffer: allocates up to WAY entries per cycle at dispatch and accepts up to CP completions per cycle from execute. It retires up to WAY contiguous ready entries per cycle in program order. On a branch mispredict it recovers at completion time: younger entries are squashed and a redirect is raised, rather than waiting for the branch to reach the head. Sits between dispatch/rename (allocation), the execute/CDB stage (completion) and the architectural map/free list (retirement).

---
 rtl/rob_nway_pkg.sv | 30 +++
 rtl/rob_nway_if.sv | 61 ++++++
 rtl/rob_nway_retire_sel.sv | 23 ++
 rtl/rob_nway.sv | 213 +++++++++++++++++++++
 tb/tb_rob_nway.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_nway_pkg.sv
// rob_nway shared types and defaults.
// Branch prediction record and mispredict check.
package rob_nway_pkg;

  localparam int ROB_DEPTH_D = 32;
  localparam int WAY_D = 2;
  localparam int CP_D = 2;
  localparam int PRF_IDX_D = 6;
  localparam int XLEN = 64;
  localparam int AREG = 5;

  typedef logic [XLEN-1:0] addr_t;

  typedef struct packed {
    logic  isbr;
    logic  bt_pd;
    addr_t ba_pd;
  } br_pred_t;

  function automatic logic is_miss(
    br_pred_t pr,
    logic     bt,
    addr_t    ba
  );
    return pr.isbr &&
      ((bt != pr.bt_pd) ||
       (bt && (ba != pr.ba_pd)));
  endfunction

endpackage

// File: rtl/rob_nway_if.sv
// rob_nway dispatch/complete/retire bus.
// master drives dispatch and completion.
interface rob_nway_if
  import rob_nway_pkg::*;
#(
  parameter int WAY = WAY_D,
  parameter int CP = CP_D,
  parameter int ROB_IDX = 5,
  parameter int PRF_IDX = PRF_IDX_D
);
  logic [WAY-1:0]               disp_valid;
  logic [WAY-1:0][PRF_IDX-1:0]  disp_pdest;
  logic [WAY-1:0][AREG-1:0]     disp_adest;
  logic [WAY-1:0][XLEN-1:0]     disp_npc;
  logic [WAY-1:0]               disp_isbr;
  logic [WAY-1:0]               disp_bt_pd;
  logic [WAY-1:0][XLEN-1:0]     disp_ba_pd;
  logic                         disp_ready;
  logic [WAY-1:0][ROB_IDX-1:0]  disp_idx;

  logic [CP-1:0]                cmp_valid;
  logic [CP-1:0][ROB_IDX-1:0]   cmp_idx;
  logic [CP-1:0]                cmp_bt;
  logic [CP-1:0][XLEN-1:0]      cmp_ba;

  logic [WAY-1:0]               ret_valid;
  logic [WAY-1:0][PRF_IDX-1:0]  ret_pdest;
  logic [WAY-1:0][AREG-1:0]     ret_adest;
  logic [WAY-1:0][XLEN-1:0]     ret_npc;

  logic                         br_miss;
  logic [XLEN-1:0]              br_target;
  logic [ROB_IDX-1:0]           br_rob_idx;
  logic [ROB_IDX:0]             free_cnt;
  logic                         empty;

  modport master (
    output disp_valid, disp_pdest, disp_adest,
    output disp_npc, disp_isbr, disp_bt_pd,
    output disp_ba_pd,
    output cmp_valid, cmp_idx, cmp_bt, cmp_ba,
    input  disp_ready, disp_idx,
    input  ret_valid, ret_pdest, ret_adest,
    input  ret_npc,
    input  br_miss, br_target, br_rob_idx,
    input  free_cnt, empty
  );

  modport slave (
    input  disp_valid, disp_pdest, disp_adest,
    input  disp_npc, disp_isbr, disp_bt_pd,
    input  disp_ba_pd,
    input  cmp_valid, cmp_idx, cmp_bt, cmp_ba,
    output disp_ready, disp_idx,
    output ret_valid, ret_pdest, ret_adest,
    output ret_npc,
    output br_miss, br_target, br_rob_idx,
    output free_cnt, empty
  );

endinterface

// File: rtl/rob_nway_retire_sel.sv
// Leading-ones counter: length of the set run
// from bit 0. Retire count and oldest pick.
module rob_retire_sel #(
  parameter int N = 2,
  parameter int KW = $clog2(N + 1)
) (
  input  logic [N-1:0]  rdy,
  output logic [KW-1:0] k
);

  logic run;

  // count the unbroken run of set bits
  always_comb begin
    k = '0;
    run = 1'b1;
    for (int i = 0; i < N; i++) begin
      run = run & rdy[i];
      if (run) k = KW'(i + 1);
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer with in-order retire
// and squash at mispredicting completion.
module rob_nway
  import rob_nway_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_D,
  parameter int ROB_IDX = $clog2(ROB_DEPTH),
  parameter int WAY = WAY_D,
  parameter int CP = CP_D,
  parameter int PRF_IDX = PRF_IDX_D
) (
  input  logic       clk,
  input  logic       reset,
  rob_nway_if.slave  bus
);

  localparam int RKW = $clog2(WAY + 1);
  localparam int CKW = $clog2(CP + 1);

  typedef logic [ROB_IDX-1:0] idx_t;
  typedef logic [ROB_IDX:0]   cnt_t;

  idx_t  head, tail, tail_n;
  cnt_t  count, count_n, free_q, ndisp;
  logic  empty_q, miss_q;
  addr_t tgt_q;
  idx_t  bidx_q;

  logic [ROB_DEPTH-1:0] vld, rdy, bt_ex;
  addr_t                ba_ex [ROB_DEPTH];
  logic [PRF_IDX-1:0]   pdest [ROB_DEPTH];
  logic [AREG-1:0]      adest [ROB_DEPTH];
  addr_t                npc   [ROB_DEPTH];
  br_pred_t             pred  [ROB_DEPTH];

  logic [WAY-1:0] hrdy;
  logic [RKW-1:0] k;
  logic [CP-1:0]  hit, miss, lose;
  idx_t           cage [CP];
  logic [CKW-1:0] w;
  idx_t           widx, wage;
  addr_t          wtgt;
  logic           any_miss, fire;

  function automatic idx_t age(idx_t i, idx_t h);
    return i - h;
  endfunction

  // valid&ready window starting at head
  always_comb begin
    hrdy = '0;
    for (int i = 0; i < WAY; i++)
      hrdy[i] = vld[head + idx_t'(i)] &
                rdy[head + idx_t'(i)];
  end

  rob_retire_sel #(.N(WAY), .KW(RKW)) u_ret (
    .rdy (hrdy),
    .k   (k)
  );

  // retiring lanes read straight from head
  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      bus.ret_valid[i] = RKW'(i) < k;
      bus.ret_pdest[i] = pdest[head + idx_t'(i)];
      bus.ret_adest[i] = adest[head + idx_t'(i)];
      bus.ret_npc[i]   = npc[head + idx_t'(i)];
    end
  end

  // completion hits and mispredict detect
  always_comb begin
    hit = '0;
    miss = '0;
    cage = '{default: '0};
    for (int p = 0; p < CP; p++) begin
      cage[p] = age(bus.cmp_idx[p], head);
      hit[p]  = bus.cmp_valid[p] &
                vld[bus.cmp_idx[p]];
      miss[p] = hit[p] & is_miss(
        pred[bus.cmp_idx[p]],
        bus.cmp_bt[p], bus.cmp_ba[p]);
    end
  end

  // a port loses if any older miss exists
  always_comb begin
    lose = ~miss;
    for (int p = 0; p < CP; p++)
      for (int q = 0; q < CP; q++)
        if (miss[q] && (cage[q] < cage[p] ||
            (cage[q] == cage[p] && q < p)))
          lose[p] = 1'b1;
  end

  rob_retire_sel #(.N(CP), .KW(CKW)) u_old (
    .rdy (lose),
    .k   (w)
  );

  assign any_miss = |miss;

  // winning branch index and redirect target
  always_comb begin
    widx = '0;
    wtgt = '0;
    for (int p = 0; p < CP; p++)
      if (CKW'(p) == w) begin
        widx = bus.cmp_idx[p];
        wtgt = bus.cmp_bt[p] ? bus.cmp_ba[p]
                             : npc[bus.cmp_idx[p]];
      end
  end

  assign wage = age(widx, head);

  assign bus.disp_ready = free_q >= cnt_t'(WAY);
  assign fire = bus.disp_ready & ~any_miss;

  // allocation slots and lane count
  always_comb begin
    ndisp = '0;
    for (int i = 0; i < WAY; i++) begin
      bus.disp_idx[i] = tail + idx_t'(i);
      ndisp = ndisp + cnt_t'(bus.disp_valid[i]);
    end
  end

  // next tail and occupancy
  always_comb begin
    tail_n = tail;
    count_n = count - cnt_t'(k);
    if (any_miss) begin
      tail_n = widx + idx_t'(1);
      count_n = cnt_t'(wage) + cnt_t'(1) - cnt_t'(k);
    end else if (fire) begin
      tail_n = tail + idx_t'(ndisp);
      count_n = count + ndisp - cnt_t'(k);
    end
  end

  // pointers, entry flags and redirect pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      free_q  <= cnt_t'(ROB_DEPTH);
      empty_q <= 1'b1;
      vld     <= '0;
      rdy     <= '0;
      bt_ex   <= '0;
      miss_q  <= 1'b0;
      tgt_q   <= '0;
      bidx_q  <= '0;
    end else begin
      head    <= head + idx_t'(k);
      tail    <= tail_n;
      count   <= count_n;
      free_q  <= cnt_t'(ROB_DEPTH) - count_n;
      empty_q <= count_n == '0;
      miss_q  <= any_miss;
      if (any_miss) begin
        tgt_q  <= wtgt;
        bidx_q <= widx;
      end
      for (int p = 0; p < CP; p++)
        if (hit[p] &&
            (!any_miss || cage[p] <= wage)) begin
          rdy[bus.cmp_idx[p]]   <= 1'b1;
          bt_ex[bus.cmp_idx[p]] <= bus.cmp_bt[p];
        end
      for (int i = 0; i < WAY; i++)
        if (RKW'(i) < k)
          vld[head + idx_t'(i)] <= 1'b0;
      if (fire)
        for (int i = 0; i < WAY; i++)
          if (bus.disp_valid[i]) begin
            vld[tail + idx_t'(i)] <= 1'b1;
            rdy[tail + idx_t'(i)] <= 1'b0;
          end
      if (any_miss)
        for (int e = 0; e < ROB_DEPTH; e++)
          if (age(idx_t'(e), head) > wage)
            vld[e] <= 1'b0;
    end
  end

  // payload and resolved targets, no reset
  always_ff @(posedge clk) begin
    if (fire)
      for (int i = 0; i < WAY; i++)
        if (bus.disp_valid[i]) begin
          pdest[tail + idx_t'(i)] <= bus.disp_pdest[i];
          adest[tail + idx_t'(i)] <= bus.disp_adest[i];
          npc[tail + idx_t'(i)]   <= bus.disp_npc[i];
          pred[tail + idx_t'(i)]  <= {bus.disp_isbr[i],
                                      bus.disp_bt_pd[i],
                                      bus.disp_ba_pd[i]};
        end
    for (int p = 0; p < CP; p++)
      if (hit[p])
        ba_ex[bus.cmp_idx[p]] <= bus.cmp_ba[p];
  end

  assign bus.br_miss    = miss_q;
  assign bus.br_target  = tgt_q;
  assign bus.br_rob_idx = bidx_q;
  assign bus.free_cnt   = free_q;
  assign bus.empty      = empty_q;

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway, depth 8.
// Table vectors plus hand-written corners.
module tb_rob_nway;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rob_nway_if #(
    .WAY(2), .CP(2), .ROB_IDX(3), .PRF_IDX(6)
  ) bus ();

  rob_nway #(
    .ROB_DEPTH(8), .WAY(2), .CP(2), .PRF_IDX(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  dv;
    logic [1:0]  cv;
    logic [2:0]  ci0;
    logic [2:0]  ci1;
    logic [1:0]  e_ret;
    logic [3:0]  e_free;
    logic        e_empty;
    logic        e_rdy;
    logic [11:0] e_pd;
  } vec_t;

  vec_t tv [16];
  int n_chk = 0;
  int n_pass = 0;

  always @(negedge clk)
    if (reset && bus.cmp_valid == 2'b11)
      assert (bus.cmp_idx[0] != bus.cmp_idx[1])
        else $error("duplicate completion index");

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic idle();
    bus.disp_valid = '0;
    bus.disp_pdest = '0;
    bus.disp_adest = '0;
    bus.disp_npc   = '0;
    bus.disp_isbr  = '0;
    bus.disp_bt_pd = '0;
    bus.disp_ba_pd = '0;
    bus.cmp_valid  = '0;
    bus.cmp_idx    = '0;
    bus.cmp_bt     = '0;
    bus.cmp_ba     = '0;
  endtask

  task automatic disp(input logic [1:0] dv,
                      input int pd);
    bus.disp_valid = dv;
    bus.disp_pdest[0] = 6'(pd);
    bus.disp_pdest[1] = 6'(pd + 1);
    bus.disp_npc[0] = 64'(32'h200 + 4 * pd);
    bus.disp_npc[1] = 64'(32'h204 + 4 * pd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cmp1(input int port,
                      input logic [2:0] idx,
                      input logic bt,
                      input logic [63:0] ba);
    bus.cmp_valid[port] = 1'b1;
    bus.cmp_idx[port] = idx;
    bus.cmp_bt[port] = bt;
    bus.cmp_ba[port] = ba;
  endtask

  initial begin
    //       dv     cv     ci0   ci1   ret   free  emp   rdy   pd
    tv[0]  = '{2'b11,2'b00,3'd0,3'd0,2'b00,4'd6,1'b0,1'b1,12'd0};
    tv[1]  = '{2'b11,2'b00,3'd0,3'd0,2'b00,4'd4,1'b0,1'b1,12'd0};
    tv[2]  = '{2'b11,2'b00,3'd0,3'd0,2'b00,4'd2,1'b0,1'b1,12'd0};
    tv[3]  = '{2'b11,2'b00,3'd0,3'd0,2'b00,4'd0,1'b0,1'b0,12'd0};
    tv[4]  = '{2'b11,2'b11,3'd0,3'd1,2'b11,4'd0,1'b0,1'b0,{6'd1,6'd0}};
    tv[5]  = '{2'b00,2'b11,3'd2,3'd3,2'b11,4'd2,1'b0,1'b1,{6'd3,6'd2}};
    tv[6]  = '{2'b00,2'b11,3'd4,3'd5,2'b11,4'd4,1'b0,1'b1,{6'd5,6'd4}};
    tv[7]  = '{2'b00,2'b11,3'd6,3'd7,2'b11,4'd6,1'b0,1'b1,{6'd7,6'd6}};
    tv[8]  = '{2'b00,2'b00,3'd0,3'd0,2'b00,4'd8,1'b1,1'b1,12'd0};
    tv[9]  = '{2'b11,2'b00,3'd0,3'd0,2'b00,4'd6,1'b0,1'b1,12'd0};
    tv[10] = '{2'b11,2'b00,3'd0,3'd0,2'b00,4'd4,1'b0,1'b1,12'd0};
    tv[11] = '{2'b00,2'b01,3'd3,3'd0,2'b00,4'd4,1'b0,1'b1,12'd0};
    tv[12] = '{2'b00,2'b11,3'd2,3'd1,2'b00,4'd4,1'b0,1'b1,12'd0};
    tv[13] = '{2'b00,2'b01,3'd0,3'd0,2'b11,4'd4,1'b0,1'b1,{6'd19,6'd18}};
    tv[14] = '{2'b00,2'b00,3'd0,3'd0,2'b11,4'd6,1'b0,1'b1,{6'd21,6'd20}};
    tv[15] = '{2'b00,2'b00,3'd0,3'd0,2'b00,4'd8,1'b1,1'b1,12'd0};

    idle();
    #2 reset = 1'b0;
    #1;
    chk("rst.ret", 64'(bus.ret_valid), 64'd0);
    chk("rst.free", 64'(bus.free_cnt), 64'd8);
    chk("rst.empty", 64'(bus.empty), 64'd1);
    chk("rst.rdy", 64'(bus.disp_ready), 64'd1);
    chk("rst.miss", 64'(bus.br_miss), 64'd0);
    chk("rst.tgt", bus.br_target, 64'd0);
    chk("rst.bidx", 64'(bus.br_rob_idx), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 16; v++) begin
      idle();
      disp(tv[v].dv, 2 * v);
      bus.cmp_valid = tv[v].cv;
      bus.cmp_idx[0] = tv[v].ci0;
      bus.cmp_idx[1] = tv[v].ci1;
      step();
      chk($sformatf("v%0d.ret", v),
          64'(bus.ret_valid), 64'(tv[v].e_ret));
      chk($sformatf("v%0d.free", v),
          64'(bus.free_cnt), 64'(tv[v].e_free));
      chk($sformatf("v%0d.empty", v),
          64'(bus.empty), 64'(tv[v].e_empty));
      chk($sformatf("v%0d.rdy", v),
          64'(bus.disp_ready), 64'(tv[v].e_rdy));
      chk($sformatf("v%0d.miss", v),
          64'(bus.br_miss), 64'd0);
      if (tv[v].e_ret == 2'b11)
        chk($sformatf("v%0d.pd", v),
            64'(bus.ret_pdest), 64'(tv[v].e_pd));
    end
    chk("tbl.didx", 64'(bus.disp_idx),
        64'({3'd5, 3'd4}));

    // single mispredict at idx2
    do_reset();
    idle(); disp(2'b11, 0); step();
    idle(); disp(2'b11, 2);
    bus.disp_isbr = 2'b01;
    step();
    idle(); disp(2'b11, 4); step();
    idle(); cmp1(0, 3'd2, 1'b1, 64'h1000); step();
    chk("sq.miss", 64'(bus.br_miss), 64'd1);
    chk("sq.tgt", bus.br_target, 64'h1000);
    chk("sq.bidx", 64'(bus.br_rob_idx), 64'd2);
    chk("sq.tail", 64'(bus.disp_idx[0]), 64'd3);
    chk("sq.free", 64'(bus.free_cnt), 64'd5);
    chk("sq.ret", 64'(bus.ret_valid), 64'd0);
    idle(); step();
    chk("sq.pulse", 64'(bus.br_miss), 64'd0);
    chk("sq.free2", 64'(bus.free_cnt), 64'd5);

    // two mispredicts, older on port 1
    do_reset();
    idle(); disp(2'b11, 0);
    bus.disp_isbr = 2'b10;
    step();
    idle(); disp(2'b11, 2); step();
    idle(); disp(2'b11, 4);
    bus.disp_isbr = 2'b01;
    step();
    idle();
    cmp1(0, 3'd4, 1'b1, 64'h44);
    cmp1(1, 3'd1, 1'b1, 64'h11);
    step();
    chk("mm.miss", 64'(bus.br_miss), 64'd1);
    chk("mm.bidx", 64'(bus.br_rob_idx), 64'd1);
    chk("mm.tgt", bus.br_target, 64'h11);
    chk("mm.tail", 64'(bus.disp_idx[0]), 64'd2);
    chk("mm.free", 64'(bus.free_cnt), 64'd6);
    idle(); cmp1(0, 3'd0, 1'b0, 64'h0); step();
    chk("mm.ret", 64'(bus.ret_valid), 64'd3);
    idle(); step();
    chk("mm.empty", 64'(bus.empty), 64'd1);
    chk("mm.free2", 64'(bus.free_cnt), 64'd8);

    // squash with dispatch and retire, tail wraps
    do_reset();
    idle(); disp(2'b11, 0); step();
    idle(); disp(2'b11, 2); step();
    idle(); disp(2'b11, 4); step();
    idle(); disp(2'b11, 6);
    bus.disp_isbr = 2'b10;
    step();
    chk("sw.full", 64'(bus.free_cnt), 64'd0);
    idle(); cmp1(0, 3'd0, 1'b0, 64'h0);
    cmp1(1, 3'd1, 1'b0, 64'h0); step();
    idle(); cmp1(0, 3'd2, 1'b0, 64'h0);
    cmp1(1, 3'd3, 1'b0, 64'h0); step();
    idle(); cmp1(0, 3'd4, 1'b0, 64'h0);
    cmp1(1, 3'd5, 1'b0, 64'h0); step();
    idle(); cmp1(0, 3'd6, 1'b0, 64'h0); step();
    chk("sw.ret6", 64'(bus.ret_valid), 64'd1);
    chk("sw.free6", 64'(bus.free_cnt), 64'd6);
    idle(); disp(2'b11, 20);
    cmp1(0, 3'd7, 1'b1, 64'h7000);
    #1;
    chk("sw.retpre", 64'(bus.ret_valid), 64'd1);
    chk("sw.pd6", 64'(bus.ret_pdest[0]), 64'd6);
    step();
    chk("sw.miss", 64'(bus.br_miss), 64'd1);
    chk("sw.bidx", 64'(bus.br_rob_idx), 64'd7);
    chk("sw.tgt", bus.br_target, 64'h7000);
    chk("sw.tail", 64'(bus.disp_idx[0]), 64'd0);
    chk("sw.free", 64'(bus.free_cnt), 64'd7);
    chk("sw.ret7", 64'(bus.ret_valid), 64'd1);
    idle(); step();
    chk("sw.empty", 64'(bus.empty), 64'd1);
    chk("sw.free8", 64'(bus.free_cnt), 64'd8);

    // asynchronous reset between edges
    do_reset();
    idle(); disp(2'b11, 0); step();
    idle(); disp(2'b11, 2); step();
    idle(); disp(2'b01, 4); step();
    chk("ar.free", 64'(bus.free_cnt), 64'd3);
    idle(); cmp1(0, 3'd0, 1'b0, 64'h0); step();
    chk("ar.ret", 64'(bus.ret_valid), 64'd1);
    idle();
    #3 reset = 1'b0;
    #1;
    chk("ar.ret0", 64'(bus.ret_valid), 64'd0);
    chk("ar.free8", 64'(bus.free_cnt), 64'd8);
    chk("ar.empty", 64'(bus.empty), 64'd1);
    chk("ar.rdy", 64'(bus.disp_ready), 64'd1);
    chk("ar.miss", 64'(bus.br_miss), 64'd0);
    chk("ar.didx", 64'(bus.disp_idx),
        64'({3'd1, 3'd0}));
    #2 reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
